// File: rtl/color_pkg.sv
// Colour codes shared between the classifier and the face-scan/solver logic.
package color_pkg;

    typedef logic [2:0] color_t;

    localparam color_t COL_W       = 3'd0;
    localparam color_t COL_O       = 3'd1;
    localparam color_t COL_G       = 3'd2;
    localparam color_t COL_R       = 3'd3;
    localparam color_t COL_B       = 3'd4;
    localparam color_t COL_Y       = 3'd5;
    localparam color_t COL_UNKNOWN = 3'd7;

endpackage

// File: rtl/color_classifier_if.sv
// Sensor sample input and classified colour output bundle.
interface color_classifier_if #(
    parameter int CW = 8
);
    import color_pkg::*;

    logic          sample_valid;
    logic [CW-1:0] red;
    logic [CW-1:0] green;
    logic [CW-1:0] blue;

    color_t        color;
    logic          color_valid;
    logic          color_stable;
    color_t        raw_color;
    logic          raw_valid;

    // Sensor side / consumer side
    modport master (
        output sample_valid, red, green, blue,
        input  color, color_valid, color_stable, raw_color, raw_valid
    );

    // Classifier side
    modport slave (
        input  sample_valid, red, green, blue,
        output color, color_valid, color_stable, raw_color, raw_valid
    );

endinterface

// File: rtl/color_classify.sv
// Registered per-frame classification of averaged RGB into a colour code.
module color_classify
    import color_pkg::*;
#(
    parameter int CW        = 8,
    parameter int WHITE_MIN = 160,
    parameter int DARK_MAX  = 40,
    parameter int YEL_DELTA = 40,
    parameter int ORG_DELTA = 110
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic [CW-1:0] i_avg_r,
    input  logic [CW-1:0] i_avg_g,
    input  logic [CW-1:0] i_avg_b,
    input  logic          i_avg_valid,
    output color_t        o_raw_color,
    output logic          o_raw_valid
);

    localparam logic [CW-1:0] L_WHITE = CW'(WHITE_MIN);
    localparam logic [CW-1:0] L_DARK  = CW'(DARK_MAX);
    localparam logic [CW-1:0] L_YEL   = CW'(YEL_DELTA);
    localparam logic [CW-1:0] L_ORG   = CW'(ORG_DELTA);

    logic [CW-1:0] w_max_rg;
    logic [CW-1:0] w_min_rg;
    logic [CW-1:0] w_max;
    logic [CW-1:0] w_min;
    logic [CW-1:0] w_r_minus_g;
    color_t        w_class;
    color_t        r_raw_color;
    logic          r_raw_valid;

    assign w_max_rg    = (i_avg_r > i_avg_g) ? i_avg_r : i_avg_g;
    assign w_min_rg    = (i_avg_r < i_avg_g) ? i_avg_r : i_avg_g;
    assign w_max       = (w_max_rg > i_avg_b) ? w_max_rg : i_avg_b;
    assign w_min       = (w_min_rg < i_avg_b) ? w_min_rg : i_avg_b;
    // Only consulted on the red-dominant branch where r >= g, so no wrap.
    assign w_r_minus_g = i_avg_r - i_avg_g;

    // Priority-ordered classification rules, first match wins
    always_comb begin
        w_class = COL_R;
        if (w_min >= L_WHITE) begin
            w_class = COL_W;
        end else if (w_max < L_DARK) begin
            w_class = COL_UNKNOWN;
        end else if ((i_avg_b > i_avg_r) && (i_avg_b > i_avg_g)) begin
            w_class = COL_B;
        end else if ((i_avg_g > i_avg_r) && (i_avg_g >= i_avg_b)) begin
            w_class = COL_G;
        end else if (w_r_minus_g <= L_YEL) begin
            w_class = COL_Y;
        end else if (w_r_minus_g <= L_ORG) begin
            w_class = COL_O;
        end else begin
            w_class = COL_R;
        end
    end

    // Register the classification; clear kills a frame about to land here
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_raw_color <= COL_UNKNOWN;
            r_raw_valid <= 1'b0;
        end else if (i_clear) begin
            r_raw_valid <= 1'b0;
        end else begin
            r_raw_valid <= i_avg_valid;
            if (i_avg_valid) begin
                r_raw_color <= w_class;
            end
        end
    end

    assign o_raw_color = r_raw_color;
    assign o_raw_valid = r_raw_valid;

endmodule

// File: rtl/color_classifier.sv
// Frame-averaging colour classifier with a consecutive-frame stability filter.
module color_classifier
    import color_pkg::*;
#(
    parameter int CW           = 8,
    parameter int LOG_SAMPLES  = 2,
    parameter int STABLE_COUNT = 3,
    parameter int WHITE_MIN    = 160,
    parameter int DARK_MAX     = 40,
    parameter int YEL_DELTA    = 40,
    parameter int ORG_DELTA    = 110
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    color_classifier_if.slave io_bus
);

    localparam int                     AW       = CW + LOG_SAMPLES;
    localparam logic [LOG_SAMPLES-1:0] LAST_IDX = '1;
    localparam logic [3:0]             RUN_MAX  = 4'(STABLE_COUNT);

    // Accumulation
    logic [LOG_SAMPLES-1:0] r_cnt;
    logic [AW-1:0]          r_acc_r, r_acc_g, r_acc_b;
    logic [AW-1:0]          w_nxt_r, w_nxt_g, w_nxt_b;
    logic [AW-1:0]          r_sum_r, r_sum_g, r_sum_b;
    logic                   r_sum_vld;

    // Stage A
    logic [CW-1:0]          r_avg_r, r_avg_g, r_avg_b;
    logic                   r_avg_vld;

    // Stage B
    color_t                 w_raw_color;
    logic                   w_raw_valid;

    // Stage C
    logic [3:0]             r_run;
    logic [3:0]             w_run_nxt;
    color_t                 r_last_raw;
    color_t                 r_color;
    logic                   r_color_valid;
    logic                   r_color_stable;

    assign w_nxt_r = r_acc_r + AW'(io_bus.red);
    assign w_nxt_g = r_acc_g + AW'(io_bus.green);
    assign w_nxt_b = r_acc_b + AW'(io_bus.blue);

    // Sum samples; the final sample of a frame goes straight into the latched
    // sums so the next frame can start on the following cycle
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt     <= '0;
            r_acc_r   <= '0;
            r_acc_g   <= '0;
            r_acc_b   <= '0;
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_sum_vld <= 1'b0;
        end else begin
            r_sum_vld <= 1'b0;
            if (io_bus.sample_valid) begin
                if (r_cnt == LAST_IDX) begin
                    r_sum_r   <= w_nxt_r;
                    r_sum_g   <= w_nxt_g;
                    r_sum_b   <= w_nxt_b;
                    r_sum_vld <= 1'b1;
                    r_acc_r   <= '0;
                    r_acc_g   <= '0;
                    r_acc_b   <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc_r   <= w_nxt_r;
                    r_acc_g   <= w_nxt_g;
                    r_acc_b   <= w_nxt_b;
                    r_cnt     <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Stage A: truncating average of the latched frame sums
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_avg_r   <= '0;
            r_avg_g   <= '0;
            r_avg_b   <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= r_sum_vld;
            if (r_sum_vld) begin
                r_avg_r <= CW'(r_sum_r >> LOG_SAMPLES);
                r_avg_g <= CW'(r_sum_g >> LOG_SAMPLES);
                r_avg_b <= CW'(r_sum_b >> LOG_SAMPLES);
            end
        end
    end

    color_classify #(
        .CW        (CW),
        .WHITE_MIN (WHITE_MIN),
        .DARK_MAX  (DARK_MAX),
        .YEL_DELTA (YEL_DELTA),
        .ORG_DELTA (ORG_DELTA)
    ) u_classify (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_avg_r     (r_avg_r),
        .i_avg_g     (r_avg_g),
        .i_avg_b     (r_avg_b),
        .i_avg_valid (r_avg_vld),
        .o_raw_color (w_raw_color),
        .o_raw_valid (w_raw_valid)
    );

    // Run length of identical frames, saturating at the publish threshold
    always_comb begin
        w_run_nxt = 4'd1;
        if (w_raw_color == r_last_raw) begin
            w_run_nxt = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
        end
    end

    // Stage C: stability filter; publishes once per newly stable colour
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_run          <= '0;
            r_last_raw     <= '0;
            r_color        <= COL_UNKNOWN;
            r_color_valid  <= 1'b0;
            r_color_stable <= 1'b0;
        end else if (i_clear) begin
            r_run          <= '0;
            r_last_raw     <= '0;
            r_color_valid  <= 1'b0;
            r_color_stable <= 1'b0;
        end else begin
            r_color_valid <= 1'b0;
            if (w_raw_valid) begin
                r_last_raw <= w_raw_color;
                if (w_raw_color == COL_UNKNOWN) begin
                    r_run          <= '0;
                    r_color_stable <= 1'b0;
                end else begin
                    r_run <= w_run_nxt;
                    if ((w_run_nxt == RUN_MAX) &&
                        ((r_color != w_raw_color) || !r_color_stable)) begin
                        r_color        <= w_raw_color;
                        r_color_stable <= 1'b1;
                        r_color_valid  <= 1'b1;
                    end else if (w_raw_color != r_color) begin
                        r_color_stable <= 1'b0;
                    end
                end
            end
        end
    end

    assign io_bus.color        = r_color;
    assign io_bus.color_valid  = r_color_valid;
    assign io_bus.color_stable = r_color_stable;
    assign io_bus.raw_color    = w_raw_color;
    assign io_bus.raw_valid    = w_raw_valid;

endmodule

// File: tb/tb_color_classifier.sv
// Scoreboard bench: stimulus pushes expected raw/published colours, a
// negedge monitor pops and compares whenever a DUT output pulses.
module tb_color_classifier;
    import color_pkg::*;

    localparam int CW = 8;

    typedef struct {
        color_t col;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_t = 0;

    color_t q_raw3[$];
    color_t q_raw1[$];
    exp_t   q_col3[$];
    exp_t   q_col1[$];

    color_classifier_if #(.CW(CW)) bus3 ();
    color_classifier_if #(.CW(CW)) bus1 ();

    color_classifier #(.CW(CW), .LOG_SAMPLES(2), .STABLE_COUNT(3)) dut3 (
        .i_clock (clk),
        .i_reset (rst),
        .i_clear (clr),
        .io_bus  (bus3)
    );

    color_classifier #(.CW(CW), .LOG_SAMPLES(2), .STABLE_COUNT(1)) dut1 (
        .i_clock (clk),
        .i_reset (rst),
        .i_clear (clr),
        .io_bus  (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every raw/published pulse against the scoreboard
    always @(negedge clk) begin
        color_t e;
        exp_t   ec;
        if (bus3.raw_valid) begin
            if (q_raw3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dut3_raw_extra: got %0d, expected no pulse", bus3.raw_color);
            end else begin
                e = q_raw3.pop_front();
                check("dut3_raw", int'(bus3.raw_color), int'(e));
            end
        end
        if (bus3.color_valid) begin
            if (q_col3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dut3_color_extra: got %0d, expected no pulse", bus3.color);
            end else begin
                ec = q_col3.pop_front();
                check("dut3_color", int'(bus3.color), int'(ec.col));
                if (ec.cyc >= 0) check("dut3_color_latency", cyc, ec.cyc);
            end
        end
        if (bus1.raw_valid) begin
            if (q_raw1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dut1_raw_extra: got %0d, expected no pulse", bus1.raw_color);
            end else begin
                e = q_raw1.pop_front();
                check("dut1_raw", int'(bus1.raw_color), int'(e));
            end
        end
        if (bus1.color_valid) begin
            if (q_col1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dut1_color_extra: got %0d, expected no pulse", bus1.color);
            end else begin
                ec = q_col1.pop_front();
                check("dut1_color", int'(bus1.color), int'(ec.col));
                if (ec.cyc >= 0) check("dut1_color_latency", cyc, ec.cyc);
            end
        end
    end

    // One sample to DUT sel (0: dut3, 1: dut1), optionally with clear
    task automatic smp(input bit sel, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit c);
        if (sel) begin
            bus1.sample_valid = 1'b1; bus1.red = r; bus1.green = g; bus1.blue = b;
        end else begin
            bus3.sample_valid = 1'b1; bus3.red = r; bus3.green = g; bus3.blue = b;
        end
        clr = c;
        @(posedge clk);
        #1;
        bus1.sample_valid = 1'b0;
        bus3.sample_valid = 1'b0;
        clr = 1'b0;
        last_t = cyc;
    endtask

    task automatic frame(input bit sel, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
        repeat (4) smp(sel, r, g, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_col(input bit sel, input color_t c, input int t);
        exp_t x;
        x.col = c;
        x.cyc = t;
        if (sel) q_col1.push_back(x);
        else     q_col3.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        bus3.sample_valid = 1'b0; bus3.red = '0; bus3.green = '0; bus3.blue = '0;
        bus1.sample_valid = 1'b0; bus1.red = '0; bus1.green = '0; bus1.blue = '0;
        idle(3);
        check("rst_color",    int'(bus3.color), 7);
        check("rst_cvalid",   int'(bus3.color_valid), 0);
        check("rst_stable",   int'(bus3.color_stable), 0);
        check("rst_raw",      int'(bus3.raw_color), 7);
        check("rst_rvalid",   int'(bus3.raw_valid), 0);
        check("rst_color_d1", int'(bus1.color), 7);
        rst = 1'b0;
        idle(1);

        // 1: three white frames back-to-back, single publish 3 cycles after the last sample
        repeat (3) q_raw3.push_back(COL_W);
        repeat (3) frame(1'b0, 8'd250, 8'd240, 8'd230);
        push_col(1'b0, COL_W, last_t + 3);
        idle(6);
        check("t1_color",  int'(bus3.color), 0);
        check("t1_stable", int'(bus3.color_stable), 1);

        // 4: W,W,R,W,W,W from stable W; R drops stability, republish on 6th frame
        q_raw3.push_back(COL_W); q_raw3.push_back(COL_W); q_raw3.push_back(COL_R);
        frame(1'b0, 8'd250, 8'd240, 8'd230);
        frame(1'b0, 8'd250, 8'd240, 8'd230);
        frame(1'b0, 8'd200, 8'd30, 8'd20);
        idle(4);
        check("t4_stable_drop", int'(bus3.color_stable), 0);
        check("t4_color_hold",  int'(bus3.color), 0);
        repeat (3) q_raw3.push_back(COL_W);
        repeat (3) frame(1'b0, 8'd250, 8'd240, 8'd230);
        push_col(1'b0, COL_W, last_t + 3);
        idle(6);
        check("t4_stable", int'(bus3.color_stable), 1);
        check("t4_color",  int'(bus3.color), 0);

        // 2: constant-frame sweep on the STABLE_COUNT=1 instance
        q_raw1.push_back(COL_R); q_raw1.push_back(COL_O); q_raw1.push_back(COL_Y);
        q_raw1.push_back(COL_G); q_raw1.push_back(COL_B); q_raw1.push_back(COL_UNKNOWN);
        q_raw1.push_back(COL_Y);
        frame(1'b1, 8'd200, 8'd30, 8'd20);   push_col(1'b1, COL_R, last_t + 3);
        frame(1'b1, 8'd220, 8'd130, 8'd20);  push_col(1'b1, COL_O, last_t + 3);
        frame(1'b1, 8'd200, 8'd180, 8'd30);  push_col(1'b1, COL_Y, last_t + 3);
        frame(1'b1, 8'd30, 8'd180, 8'd60);   push_col(1'b1, COL_G, last_t + 3);
        frame(1'b1, 8'd20, 8'd60, 8'd200);   push_col(1'b1, COL_B, last_t + 3);
        frame(1'b1, 8'd20, 8'd20, 8'd30);
        idle(4);
        check("t2_unknown_stable", int'(bus1.color_stable), 0);
        check("t2_unknown_hold",   int'(bus1.color), 4);
        frame(1'b1, 8'd100, 8'd100, 8'd100); push_col(1'b1, COL_Y, last_t + 3);
        idle(5);
        check("t2_tie_color",  int'(bus1.color), 5);
        check("t2_tie_stable", int'(bus1.color_stable), 1);

        // 3: truncating average 46>>2 = 11 -> too dark
        q_raw1.push_back(COL_UNKNOWN);
        smp(1'b1, 8'd10, 8'd0, 8'd0, 1'b0);
        smp(1'b1, 8'd11, 8'd0, 8'd0, 1'b0);
        smp(1'b1, 8'd12, 8'd0, 8'd0, 1'b0);
        smp(1'b1, 8'd13, 8'd0, 8'd0, 1'b0);
        idle(5);
        check("t3_stable", int'(bus1.color_stable), 0);
        check("t3_color",  int'(bus1.color), 5);

        // 5: clear alongside the 3rd sample; following 4 samples alone form a Y frame
        smp(1'b0, 8'd250, 8'd0, 8'd0, 1'b0);
        smp(1'b0, 8'd250, 8'd0, 8'd0, 1'b0);
        smp(1'b0, 8'd250, 8'd0, 8'd0, 1'b1);
        check("t5_clear_stable", int'(bus3.color_stable), 0);
        check("t5_clear_color",  int'(bus3.color), 0);
        q_raw3.push_back(COL_Y);
        frame(1'b0, 8'd200, 8'd180, 8'd30);
        idle(5);
        check("t5_stable", int'(bus3.color_stable), 0);
        check("t5_color",  int'(bus3.color), 0);

        // 6: reset lands between stage A and stage B
        frame(1'b0, 8'd250, 8'd240, 8'd230);
        idle(1);
        rst = 1'b1;
        idle(1);
        check("t6_rvalid", int'(bus3.raw_valid), 0);
        check("t6_raw",    int'(bus3.raw_color), 7);
        check("t6_color",  int'(bus3.color), 7);
        check("t6_cvalid", int'(bus3.color_valid), 0);
        check("t6_stable", int'(bus3.color_stable), 0);
        rst = 1'b0;
        idle(6);

        check("q_raw3_empty", q_raw3.size(), 0);
        check("q_col3_empty", q_col3.size(), 0);
        check("q_raw1_empty", q_raw1.size(), 0);
        check("q_col1_empty", q_col1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
